mac_rx_pkt_fifo: RTL and testbench

Packet-aware receive FIFO between the MAC receive interface and the header buffer, replacing the fixed 8-bit byte FIFO. It is parametrised in data width and depth, and carries a per-beat error flag. It supports two modes: cut-through, and store-and-forward, where packets the MAC marks bad are dropped. Reads are first-word-fall-through, so the head beat is visible with zero latency.

---
 rtl/net_pkg.sv | 14 +
 rtl/sdp_ram.sv | 23 ++
 rtl/mac_rx_pkt_fifo.sv | 165 ++++++++++++++++
 tb/tb_mac_rx_pkt_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// Shared definitions for the receive packet FIFO: entry field offsets and write-FSM states.
package net_pkg;

  // Flag positions counted upward from the top of the data field in a stored entry.
  localparam int LAST_BIT = 0;
  localparam int ERR_BIT  = 1;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_DISCARD
  } wr_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module sdp_ram #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_rx_pkt_fifo.sv
// Packet-aware MAC receive FIFO, first-word-fall-through read side.
// Cut-through, or store-and-forward with drop of bad and oversized packets.
module mac_rx_pkt_fifo
  import net_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter bit STORE_FWD = 1'b1,
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last,
  input  logic              rx_err,
  output logic              rx_ready,
  output logic              fifo_valid,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_last,
  output logic              fifo_err,
  input  logic              fifo_ready,
  output logic [ADDR_W:0]   level,
  output logic              almost_full,
  output logic              drop_pulse,
  output logic [15:0]       drop_cnt
);

  localparam int              ENTRY_W  = DATA_W + 2;
  localparam int              LAST_IDX = DATA_W + LAST_BIT;
  localparam int              ERR_IDX  = DATA_W + ERR_BIT;
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_LVL   = AF_THRESH[ADDR_W:0];

  wr_state_e          state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]    wr_commit_q, wr_commit_d;
  logic [ADDR_W:0]    rd_ptr_q;
  logic               drop_pulse_q;
  logic [15:0]        drop_cnt_q;
  logic               wr_en;
  logic               drop_d;
  logic               full;
  logic               rd_en;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = (level == FULL_LVL);
  assign fifo_valid = (rd_ptr_q != wr_commit_q);
  assign rd_en      = fifo_valid && fifo_ready;

  always_comb begin
    wr_entry                 = '0;
    wr_entry[DATA_W-1:0]     = rx_data;
    wr_entry[LAST_IDX]       = rx_last;
    wr_entry[ERR_IDX]        = !STORE_FWD && rx_err && rx_last;
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    drop_d      = 1'b0;
    rx_ready    = !full;
    if (!STORE_FWD) begin
      if (rx_valid && !full) begin
        wr_en       = 1'b1;
        wr_ptr_d    = wr_ptr_q + PTR_ONE;
        wr_commit_d = wr_ptr_q + PTR_ONE;
      end
    end else begin
      unique case (state_q)
        WR_IDLE: wr_en = rx_valid && !full;
        WR_ACCEPT: begin
          if (!full) begin
            rx_ready = 1'b1;
            wr_en    = rx_valid;
          end else if (wr_commit_q != rd_ptr_q) begin
            rx_ready = 1'b0;
          end else begin
            // Whole FIFO holds this one packet: it can never commit, so drop it.
            rx_ready = 1'b1;
            if (rx_valid) begin
              wr_ptr_d = wr_commit_q;
              if (rx_last) begin
                drop_d  = 1'b1;
                state_d = WR_IDLE;
              end else begin
                state_d = WR_DISCARD;
              end
            end
          end
        end
        WR_DISCARD: begin
          rx_ready = 1'b1;
          if (rx_valid && rx_last) begin
            drop_d  = 1'b1;
            state_d = WR_IDLE;
          end
        end
        default: state_d = WR_IDLE;
      endcase

      if (wr_en) begin
        if (!rx_last) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          state_d  = WR_ACCEPT;
        end else begin
          state_d = WR_IDLE;
          if (rx_err) begin
            wr_ptr_d = wr_commit_q;
            drop_d   = 1'b1;
          end else begin
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            wr_commit_d = wr_ptr_q + PTR_ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      drop_pulse_q <= drop_d;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  sdp_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q[ADDR_W-1:0]),
    .wdata_i(wr_entry),
    .raddr_i(rd_ptr_q[ADDR_W-1:0]),
    .rdata_o(rd_entry)
  );

  // Memory is not reset, so flags are gated until a committed beat is present.
  assign fifo_data   = rd_entry[DATA_W-1:0];
  assign fifo_last   = fifo_valid && rd_entry[LAST_IDX];
  assign fifo_err    = !STORE_FWD && fifo_valid && rd_entry[ERR_IDX];
  assign almost_full = (level >= AF_LVL);
  assign drop_pulse  = drop_pulse_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_pkt_fifo.sv
// Scoreboard bench: one cut-through and one store-and-forward instance, DEPTH=16, shared stimulus.
module tb_mac_rx_pkt_fifo;

  localparam int DW  = 8;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          mode;  // 0 = cut-through instance, 1 = store-and-forward instance
  logic          rx_valid, rx_last, rx_err, fifo_ready;
  logic [DW-1:0] rx_data;

  logic          ct_rx_ready, ct_fifo_valid, ct_fifo_last, ct_fifo_err, ct_af, ct_drop_pulse;
  logic [DW-1:0] ct_fifo_data;
  logic [AW:0]   ct_level;
  logic [15:0]   ct_drop_cnt;
  logic          sf_rx_ready, sf_fifo_valid, sf_fifo_last, sf_fifo_err, sf_af, sf_drop_pulse;
  logic [DW-1:0] sf_fifo_data;
  logic [AW:0]   sf_level;
  logic [15:0]   sf_drop_cnt;

  mac_rx_pkt_fifo #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .STORE_FWD(1'b0), .AF_THRESH(12)) u_ct (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid && !mode), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err),
    .rx_ready(ct_rx_ready), .fifo_valid(ct_fifo_valid), .fifo_data(ct_fifo_data),
    .fifo_last(ct_fifo_last), .fifo_err(ct_fifo_err), .fifo_ready(fifo_ready && !mode),
    .level(ct_level), .almost_full(ct_af), .drop_pulse(ct_drop_pulse), .drop_cnt(ct_drop_cnt)
  );

  mac_rx_pkt_fifo #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .STORE_FWD(1'b1), .AF_THRESH(12)) u_sf (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid && mode), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err),
    .rx_ready(sf_rx_ready), .fifo_valid(sf_fifo_valid), .fifo_data(sf_fifo_data),
    .fifo_last(sf_fifo_last), .fifo_err(sf_fifo_err), .fifo_ready(fifo_ready && mode),
    .level(sf_level), .almost_full(sf_af), .drop_pulse(sf_drop_pulse), .drop_cnt(sf_drop_cnt)
  );

  logic          o_rx_ready, o_fifo_valid, o_fifo_last, o_fifo_err, o_af, o_drop_pulse;
  logic [DW-1:0] o_fifo_data;
  logic [AW:0]   o_level;
  logic [15:0]   o_drop_cnt;

  assign o_rx_ready   = mode ? sf_rx_ready   : ct_rx_ready;
  assign o_fifo_valid = mode ? sf_fifo_valid : ct_fifo_valid;
  assign o_fifo_data  = mode ? sf_fifo_data  : ct_fifo_data;
  assign o_fifo_last  = mode ? sf_fifo_last  : ct_fifo_last;
  assign o_fifo_err   = mode ? sf_fifo_err   : ct_fifo_err;
  assign o_level      = mode ? sf_level      : ct_level;
  assign o_af         = mode ? sf_af         : ct_af;
  assign o_drop_pulse = mode ? sf_drop_pulse : ct_drop_pulse;
  assign o_drop_cnt   = mode ? sf_drop_cnt   : ct_drop_cnt;

  int         n_tests = 0;
  int         n_fail = 0;
  int         pulse_cnt = 0;
  logic [9:0] exp_q[$];  // {err, last, data}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read-side monitor: every beat the DUT hands over is matched against the scoreboard.
  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (rst_n) begin
      if (o_drop_pulse) pulse_cnt++;
      if (o_fifo_valid && fifo_ready) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", {31'd0, o_fifo_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] mode %0d rd %03h", mode, {o_fifo_err, o_fifo_last, o_fifo_data});
          chk("rd_entry", {22'd0, o_fifo_err, o_fifo_last, o_fifo_data}, {22'd0, e});
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic e, input bit hidden);
    int n;
    rx_data  = d;
    rx_last  = l;
    rx_err   = e;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_rx_ready) chk("rx_ready_timeout", {31'd0, o_rx_ready}, 32'd1);
    if (hidden) chk("sf_hidden", {31'd0, o_fifo_valid}, 32'd0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (!mode) exp_q.push_back({e & l, l, d});
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic bad, input bit hidden);
    logic [9:0]    pk[$];
    logic [DW-1:0] d;
    logic          l;
    for (int i = 0; i < len; i++) begin
      d = base + DW'(i);
      l = (i == len - 1);
      send_beat(d, l, bad && l, hidden);
      pk.push_back({1'b0, l, d});
    end
    if (mode && !bad && len <= DEP) begin
      foreach (pk[i]) exp_q.push_back(pk[i]);
    end
    $display("[TB] mode %0d pkt len %0d base %02h bad %0d", mode, len, base, bad);
  endtask

  task automatic drain();
    int n;
    fifo_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("drain_valid", {31'd0, o_fifo_valid}, 32'd0);
    @(posedge clk);
    #1;
    fifo_ready = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_rx_ready",   {31'd0, o_rx_ready},   32'd1);
    chk("rst_fifo_valid", {31'd0, o_fifo_valid}, 32'd0);
    chk("rst_fifo_last",  {31'd0, o_fifo_last},  32'd0);
    chk("rst_fifo_err",   {31'd0, o_fifo_err},   32'd0);
    chk("rst_level",      {27'd0, o_level},      32'd0);
    chk("rst_af",         {31'd0, o_af},         32'd0);
    chk("rst_drop_pulse", {31'd0, o_drop_pulse}, 32'd0);
    chk("rst_drop_cnt",   {16'd0, o_drop_cnt},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = '0; fifo_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    mode = 1'b0; #1 check_reset();
    mode = 1'b1; #1 check_reset();
    mode = 1'b0;
    @(posedge clk);
    #1;

    // Cut-through fill to full, error flag on the last beat, then drain in order.
    for (int i = 0; i < 16; i++) begin
      send_beat(DW'(i), i == 15, i == 15, 1'b0);
      if (i == 10) chk("ct_af_11", {31'd0, o_af}, 32'd0);
      if (i == 11) chk("ct_af_12", {31'd0, o_af}, 32'd1);
    end
    chk("ct_full_ready", {31'd0, o_rx_ready}, 32'd0);
    chk("ct_full_level", {27'd0, o_level}, 32'd16);
    chk("ct_full_af", {31'd0, o_af}, 32'd1);
    drain();
    chk("ct_empty_level", {27'd0, o_level}, 32'd0);

    // Store-and-forward good packet: hidden until committed.
    mode = 1'b1;
    fifo_ready = 1'b1;
    send_pkt(5, 8'h20, 1'b0, 1'b1);
    drain();

    // Bad packet dropped, following good packet kept.
    begin
      int p0;
      p0 = pulse_cnt;
      send_pkt(4, 8'h40, 1'b1, 1'b0);
      send_pkt(3, 8'h50, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("sf_err_pulses", pulse_cnt - p0, 32'd1);
      chk("sf_err_drop_cnt", {16'd0, o_drop_cnt}, 32'd1);
      chk("sf_err_level", {27'd0, o_level}, 32'd3);
      drain();
    end

    // Oversized packet discarded, then a small packet passes intact.
    fifo_ready = 1'b1;
    send_pkt(20, 8'h60, 1'b0, 1'b1);
    @(negedge clk);
    chk("sf_big_valid", {31'd0, o_fifo_valid}, 32'd0);
    chk("sf_big_level", {27'd0, o_level}, 32'd0);
    chk("sf_big_drop_cnt", {16'd0, o_drop_cnt}, 32'd2);
    @(posedge clk);
    #1;
    send_pkt(2, 8'h80, 1'b0, 1'b0);
    drain();

    // Committed data fills the FIFO behind an in-progress packet: backpressure, no drop.
    fifo_ready = 1'b0;
    send_pkt(15, 8'h90, 1'b0, 1'b0);
    fork
      send_pkt(3, 8'hB0, 1'b0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        chk("sf_bp_ready", {31'd0, o_rx_ready}, 32'd0);
        chk("sf_bp_level", {27'd0, o_level}, 32'd16);
        chk("sf_bp_af", {31'd0, o_af}, 32'd1);
        @(posedge clk);
        #1 fifo_ready = 1'b1;
      end
    join
    drain();
    chk("sf_bp_drop_cnt", {16'd0, o_drop_cnt}, 32'd2);

    // Cut-through streaming at full rate across pointer wrap.
    mode = 1'b0;
    fifo_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send_beat(DW'(i), (i % 8) == 7, 1'b0, 1'b0);
      chk("ct_stream_level", {27'd0, o_level}, 32'd1);
    end
    drain();

    // Asynchronous reset in the middle of a packet.
    mode = 1'b1;
    fifo_ready = 1'b0;
    send_pkt(2, 8'hC0, 1'b0, 1'b0);
    send_beat(8'hD0, 1'b0, 1'b0, 1'b0);
    send_beat(8'hD1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_pkt(2, 8'hE0, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
